// File: rtl/serial_add_ctrl_if.sv
// Handshake and result bundle for the bit-serial adder/subtractor.
// The requester drives start/a/b/sub; the adder returns status and result.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             co;
  logic             ovf;

  modport master (
    output start, a, b, sub,
    input  busy, done, s, co, ovf
  );

  modport slave (
    input  start, a, b, sub,
    output busy, done, s, co, ovf
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder/subtractor controller.
// One full-adder cell and a carry flop process one operand bit per clock,
// LSB first. Subtraction is A + ~B + 1: B is inverted on capture and the
// carry flop is preset to 1. The published result (s/co/ovf) only changes
// on entry to DONE, so it stays stable while the next operation runs.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input logic            clk,
  input logic            rst_n,
  serial_add_ctrl_if.slave bus
);

  localparam int              CW       = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]   LAST_CNT = CW'(WIDTH - 1);
  localparam logic [CW-1:0]   ONE_CNT  = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] s_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic             busy_q;
  logic             done_q;
  logic             co_q;
  logic             ovf_q;

  logic             sum_d;
  logic             carry_d;
  logic [WIDTH-1:0] r_d;

  // 1-bit full adder: returns {carry_out, sum}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic cin);
    full_add = {(x & y) | (x & cin) | (y & cin), x ^ y ^ cin};
  endfunction

  // Full-adder cell on the current LSBs; the new bit enters the result at the MSB.
  always_comb begin
    {carry_d, sum_d} = full_add(a_q[0], b_q[0], carry_q);
    r_d              = {sum_d, r_q[WIDTH-1:1]};
  end

  // Control FSM with datapath shift registers and registered status/result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.sub ? ~bus.b : bus.b;
            carry_q <= bus.sub;
            cnt_q   <= '0;
            r_q     <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_q     <= {1'b0, a_q[WIDTH-1:1]};
          b_q     <= {1'b0, b_q[WIDTH-1:1]};
          carry_q <= carry_d;
          r_q     <= r_d;
          cnt_q   <= cnt_q + ONE_CNT;
          if (cnt_q == LAST_CNT) begin
            // carry_q here is the carry into the MSB; carry_d the carry out of it.
            s_q     <= r_d;
            co_q    <= carry_d;
            ovf_q   <= carry_q ^ carry_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.s    = s_q;
  assign bus.co   = co_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 The block SHALL have parameter: WIDTH, 8, operand/result width in bits (legal range 2..32).
REQ-002 The block SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 The block SHALL have port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 The block SHALL have port: start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 The block SHALL have port: a  input  WIDTH  operand A, captured when start is accepted.
REQ-006 The block SHALL have port: b  input  WIDTH  operand B, captured when start is accepted.
REQ-007 The block SHALL have port: sub  input  1  0 = A+B, 1 = A-B; captured when start is accepted.
REQ-008 The block SHALL have port: busy  output  1  high while bits are being processed (RUN state).
REQ-009 The block SHALL have port: done  output  1  one-cycle pulse, high when the result is valid.
REQ-010 The block SHALL have port: s  output  WIDTH  result.
REQ-011 The block SHALL have port: co  output  1  final carry out (for sub: 1 = no borrow).
REQ-012 The block SHALL have port: ovf  output  1  two's-complement signed overflow.

Function
REQ-013 The block SHALL compute the result bit-serially, LSB first, through one internal 1-bit full-adder cell plus a carry flip-flop, processing one bit per clock.
REQ-014 The FSM SHALL have states IDLE, RUN and DONE; transitions: IDLE->RUN on start=1; RUN->DONE after exactly WIDTH bit cycles; DONE->IDLE unconditionally after one cycle.
REQ-015 On the edge accepting start, the block SHALL load the A shift register with a, load the B shift register with b (sub=0) or ~b (sub=1), set carry to sub, and clear the bit counter (width clog2(WIDTH)+1).
REQ-016 In each RUN cycle: bit = A[0]^B[0]^carry; carry <= majority(A[0], B[0], carry); A and B shift right; bit enters the internal result register at the MSB, shifting right.
REQ-017 On the final (WIDTH-th) RUN edge, the block SHALL record the carry into the MSB (carry before that bit) for overflow: ovf = carry_into_MSB ^ carry_out_of_MSB.
REQ-018 s, co and ovf SHALL update only on the transition into DONE and SHALL hold their values until the next transition into DONE or reset.
REQ-019 Latency: with start accepted on edge 0, busy SHALL be high after edges 0..WIDTH-1, and done SHALL be high for exactly the one cycle following edge WIDTH.
REQ-020 Throughput: the earliest next start acceptance SHALL be on edge WIDTH+2.
REQ-021 start=1 in RUN or DONE SHALL be ignored without effect on the operation or outputs; no queuing.
REQ-022 a, b and sub changes after acceptance SHALL have no effect on the running operation.
REQ-023 busy and done SHALL never be high simultaneously.

Reset
REQ-024 rst_n=0 SHALL immediately force state IDLE and clear busy, done, s, co, ovf, carry, counter and shift registers, including mid-RUN; the aborted operation produces no done.
REQ-025 After rst_n deasserts, the first rising edge with start=1 SHALL be accepted normally.

Verification (WIDTH=8)
REQ-026 The bench SHALL check add: a=05, b=03, sub=0 -> s=08, co=0, ovf=0; done exactly one cycle, 8 edges after the accepting edge.
REQ-027 The bench SHALL check add wrap: a=FF, b=01 -> s=00, co=1, ovf=0; then a=7F, b=01 -> s=80, co=0, ovf=1.
REQ-028 The bench SHALL check subtract: a=03, b=05, sub=1 -> s=FE, co=0, ovf=0; then a=80, b=01, sub=1 -> s=7F, co=1, ovf=1.
REQ-029 The bench SHALL check ignored start: start held high throughout an operation with a/b changing after acceptance -> result of the originally captured operands only; next acceptance on edge 10.
REQ-030 The bench SHALL check mid-operation reset: assert rst_n=0 during RUN bit 4 -> busy/done/s/co/ovf=0 asynchronously, no done pulse; after release, a=01, b=01 -> s=02.
REQ-031 The bench SHALL check back-to-back operations: two consecutive operations -> s/co/ovf from the first hold through the second's RUN and change only when the second's done asserts.
